// File: rtl/cache_ri.sv
// cache_ri: executes line refill, uncached IO read/write and invalidate-all commands for the cache.
// Latency: refill = 16 pipelined m1 reads, then a tag write, then ready; IO = one m1 transfer (+ read data), then ready.
// Backpressure: m1_waitRequest stalls request issue; m0_cmd_ready pulses for one cycle when the command completes.
module cache_ri #(
   parameter  int SIZE = 8192,
   localparam int DAW  = $clog2(SIZE / 16),
   localparam int TAW  = DAW - 4,
   localparam int TGW  = 30 - DAW
) (
   input  logic           clk,
   input  logic           rest,
   input  logic [3:0]     m0_cmd,
   input  logic           m0_cmd_valid,
   output logic           m0_cmd_ready,
   input  logic [31:0]    req_address,
   input  logic [3:0]     req_byteEnable,
   input  logic           req_read,
   input  logic           req_write,
   input  logic [31:0]    req_writeData,
   input  logic           isHaveFreeBlock,
   input  logic [1:0]     freeBlockNum,
   output logic [31:0]    io_readData,
   output logic           io_readDataValid,
   output logic [DAW-1:0] data_wAddr,
   output logic [1:0]     data_wCh,
   output logic [31:0]    data_wData,
   output logic           data_wEn,
   output logic [3:0]     data_wByteEn,
   output logic [3:0]     dre_wRe,
   output logic           dre_wEn,
   output logic [TAW-1:0] tag_wAddr,
   output logic [1:0]     tag_wCh,
   output logic [31:0]    tag_wData,
   output logic           tag_wEn,
   output logic [31:0]    m1_address,
   output logic [3:0]     m1_byteEnable,
   output logic           m1_read,
   output logic           m1_write,
   output logic [31:0]    m1_writeData,
   input  logic           m1_waitRequest,
   input  logic [31:0]    m1_readData,
   input  logic           m1_readDataValid
);

   localparam logic [3:0] CMD_IORW = 4'd1;
   localparam logic [3:0] CMD_RB   = 4'd2;
   localparam logic [3:0] CMD_CTRL = 4'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_IO_REQ, S_IO_WAIT, S_RB_REQ, S_RB_DRAIN, S_RB_TAG, S_INV, S_DONE
   } state_t;

   state_t         state, state_nxt;
   logic [3:0]     cmd_q;
   logic [31:0]    addr_q;
   logic [3:0]     be_q;
   logic           rd_q, wr_q;
   logic [31:0]    wdata_q;
   logic [1:0]     way_q;
   logic           use_victim_q;
   logic [1:0]     victim_q;
   logic [3:0]     issue_cnt;
   logic [3:0]     ret_cnt;
   logic [TAW+1:0] inv_cnt;
   logic [31:0]    io_rdata_q;

   logic [TAW-1:0] set_q;
   logic [TGW-1:0] tag_q;
   logic           rb_accept, ret_fire, ret_last, inv_last;

   assign set_q     = addr_q[DAW+1:6];
   assign tag_q     = addr_q[31:DAW+2];
   assign rb_accept = (state == S_RB_REQ) && !m1_waitRequest;
   assign ret_fire  = ((state == S_RB_REQ) || (state == S_RB_DRAIN)) && m1_readDataValid;
   assign ret_last  = ret_fire && (ret_cnt == 4'hF);
   assign inv_last  = (state == S_INV) && (&inv_cnt);
   assign io_readData = io_rdata_q;

   // State register; reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (rest) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (m0_cmd_valid) begin
               case (m0_cmd)
                  CMD_IORW: state_nxt = S_IO_REQ;
                  CMD_RB:   state_nxt = S_RB_REQ;
                  CMD_CTRL: state_nxt = S_INV;
                  default:  state_nxt = S_DONE;
               endcase
            end
         end
         S_IO_REQ: begin
            if (!m1_waitRequest) state_nxt = (rd_q && !wr_q) ? S_IO_WAIT : S_DONE;
         end
         S_IO_WAIT: begin
            if (m1_readDataValid) state_nxt = S_DONE;
         end
         S_RB_REQ: begin
            // A zero-latency memory can return the 16th word in the same cycle as the 16th accept.
            if (ret_last)                              state_nxt = S_RB_TAG;
            else if (rb_accept && issue_cnt == 4'hF)   state_nxt = S_RB_DRAIN;
         end
         S_RB_DRAIN: begin
            if (ret_last) state_nxt = S_RB_TAG;
         end
         S_RB_TAG: state_nxt = S_DONE;
         S_INV: begin
            if (inv_last) state_nxt = S_DONE;
         end
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Command capture, refill counters, victim selection and IO read data.
   always_ff @(posedge clk) begin
      if (rest) begin
         cmd_q        <= '0;
         addr_q       <= '0;
         be_q         <= '0;
         rd_q         <= 1'b0;
         wr_q         <= 1'b0;
         wdata_q      <= '0;
         way_q        <= '0;
         use_victim_q <= 1'b0;
         victim_q     <= '0;
         issue_cnt    <= '0;
         ret_cnt      <= '0;
         inv_cnt      <= '0;
         io_rdata_q   <= '0;
      end else begin
         if (state == S_IDLE && m0_cmd_valid) begin
            cmd_q        <= m0_cmd;
            addr_q       <= req_address;
            be_q         <= req_byteEnable;
            rd_q         <= req_read;
            wr_q         <= req_write;
            wdata_q      <= req_writeData;
            way_q        <= isHaveFreeBlock ? freeBlockNum : victim_q;
            use_victim_q <= !isHaveFreeBlock;
            issue_cnt    <= '0;
            ret_cnt      <= '0;
            inv_cnt      <= '0;
         end
         if (rb_accept) issue_cnt <= issue_cnt + 4'd1;
         if (ret_fire)  ret_cnt   <= ret_cnt + 4'd1;
         if (state == S_INV) begin
            inv_cnt  <= inv_cnt + (TAW+2)'(1);
            victim_q <= '0;
         end
         // Round-robin replacement advances only when it actually chose the way.
         if (state == S_RB_TAG && use_victim_q) victim_q <= victim_q + 2'd1;
         if (state == S_IO_WAIT && m1_readDataValid) io_rdata_q <= m1_readData;
      end
   end

   // Output decode: memory master, RAM write ports and completion strobes.
   always_comb begin
      m0_cmd_ready     = (state == S_DONE);
      io_readDataValid = (state == S_DONE) && (cmd_q == CMD_IORW) && rd_q && !wr_q;
      data_wAddr       = '0;
      data_wCh         = '0;
      data_wData       = '0;
      data_wEn         = 1'b0;
      data_wByteEn     = 4'h0;
      dre_wRe          = 4'h0;
      dre_wEn          = 1'b0;
      tag_wAddr        = '0;
      tag_wCh          = '0;
      tag_wData        = '0;
      tag_wEn          = 1'b0;
      m1_address       = '0;
      m1_byteEnable    = 4'h0;
      m1_read          = 1'b0;
      m1_write         = 1'b0;
      m1_writeData     = '0;
      case (state)
         S_IO_REQ: begin
            m1_address    = addr_q;
            m1_byteEnable = be_q;
            m1_write      = wr_q;
            m1_read       = rd_q && !wr_q;
            m1_writeData  = wr_q ? wdata_q : 32'h0;
         end
         S_RB_REQ: begin
            m1_read       = 1'b1;
            m1_byteEnable = 4'hF;
            m1_address    = {addr_q[31:6], issue_cnt, 2'b00};
         end
         S_RB_TAG: begin
            // Tag goes in last so the line cannot hit before every word has landed.
            tag_wEn   = 1'b1;
            tag_wAddr = set_q;
            tag_wCh   = way_q;
            tag_wData = {1'b1, {(31-TGW){1'b0}}, tag_q};
         end
         S_INV: begin
            tag_wEn   = 1'b1;
            tag_wAddr = inv_cnt[TAW+1:2];
            tag_wCh   = inv_cnt[1:0];
         end
         default: ;
      endcase
      if (ret_fire) begin
         data_wEn     = 1'b1;
         dre_wEn      = 1'b1;
         data_wAddr   = {set_q, ret_cnt};
         data_wCh     = way_q;
         data_wData   = m1_readData;
         data_wByteEn = 4'hF;
         dre_wRe      = 4'hF;
      end
   end

endmodule

// File: tb/tb_cache_ri.sv
// tb_cache_ri: table of commands driven into cache_ri against a behavioural memory,
// with expected m1 transfers and RAM writes queued at issue time and popped as the DUT produces them.
// Also covers reset state, reset in the middle of a refill and victim-counter clearing.
module tb_cache_ri;

   logic        clk = 1'b0;
   logic        rest;
   logic [3:0]  m0_cmd;
   logic        m0_cmd_valid;
   logic        m0_cmd_ready;
   logic [31:0] req_address;
   logic [3:0]  req_byteEnable;
   logic        req_read, req_write;
   logic [31:0] req_writeData;
   logic        isHaveFreeBlock;
   logic [1:0]  freeBlockNum;
   logic [31:0] io_readData;
   logic        io_readDataValid;
   logic [8:0]  data_wAddr;
   logic [1:0]  data_wCh;
   logic [31:0] data_wData;
   logic        data_wEn;
   logic [3:0]  data_wByteEn;
   logic [3:0]  dre_wRe;
   logic        dre_wEn;
   logic [4:0]  tag_wAddr;
   logic [1:0]  tag_wCh;
   logic [31:0] tag_wData;
   logic        tag_wEn;
   logic [31:0] m1_address;
   logic [3:0]  m1_byteEnable;
   logic        m1_read, m1_write;
   logic [31:0] m1_writeData;
   logic        m1_waitRequest;
   logic [31:0] m1_readData;
   logic        m1_readDataValid;

   cache_ri dut (
      .clk(clk), .rest(rest),
      .m0_cmd(m0_cmd), .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready),
      .req_address(req_address), .req_byteEnable(req_byteEnable),
      .req_read(req_read), .req_write(req_write), .req_writeData(req_writeData),
      .isHaveFreeBlock(isHaveFreeBlock), .freeBlockNum(freeBlockNum),
      .io_readData(io_readData), .io_readDataValid(io_readDataValid),
      .data_wAddr(data_wAddr), .data_wCh(data_wCh), .data_wData(data_wData),
      .data_wEn(data_wEn), .data_wByteEn(data_wByteEn),
      .dre_wRe(dre_wRe), .dre_wEn(dre_wEn),
      .tag_wAddr(tag_wAddr), .tag_wCh(tag_wCh), .tag_wData(tag_wData), .tag_wEn(tag_wEn),
      .m1_address(m1_address), .m1_byteEnable(m1_byteEnable),
      .m1_read(m1_read), .m1_write(m1_write), .m1_writeData(m1_writeData),
      .m1_waitRequest(m1_waitRequest), .m1_readData(m1_readData),
      .m1_readDataValid(m1_readDataValid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  cmd;
      logic [31:0] addr;
      logic [3:0]  be;
      logic        rd;
      logic        wr;
      logic [31:0] wdata;
      logic        free;
      logic [1:0]  fnum;
      bit          wt;
      int          lat;
      logic [1:0]  exp_way;
      int          exp_set;
      logic [31:0] exp_tag;
      logic [31:0] exp_io;
   } vec_t;

   typedef struct { bit is_wr; logic [31:0] addr; logic [3:0] be; logic [31:0] data; } mev_t;
   typedef struct { bit is_tag; logic [31:0] addr; logic [1:0] ch; logic [31:0] data; } rev_t;
   typedef struct { int due; logic [31:0] data; } rq_t;

   mev_t exp_mem[$];
   rev_t exp_ram[$];
   rq_t  rq[$];

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          last_wr_cyc = -100;
   bit          cur_wt = 1'b0;
   int          cur_lat = 1;
   logic [3:0]  cur_cmd = 4'd0;
   localparam logic [31:0] IO_RDATA = 32'h1234_5678;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: event did not match expectation (cycle %0d)", nm, cyc);
   endtask

   task automatic push_mem(input bit w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
      mev_t e;
      e.is_wr = w; e.addr = a; e.be = b; e.data = d;
      exp_mem.push_back(e);
   endtask

   task automatic push_ram(input bit t, input logic [31:0] a, input logic [1:0] c, input logic [31:0] d);
      rev_t e;
      e.is_tag = t; e.addr = a; e.ch = c; e.data = d;
      exp_ram.push_back(e);
   endtask

   // Behavioural memory plus output monitor: drives m1 responses after each rising edge,
   // observes DUT outputs at the falling edge.
   initial begin
      rq_t  r;
      mev_t me;
      rev_t re;
      m1_waitRequest   = 1'b0;
      m1_readDataValid = 1'b0;
      m1_readData      = 32'h0;
      forever begin
         @(posedge clk); #1;
         cyc++;
         if (rest) rq.delete();
         if (rq.size() > 0 && rq[0].due <= cyc) begin
            r = rq.pop_front();
            m1_readDataValid = 1'b1;
            m1_readData      = r.data;
         end else begin
            m1_readDataValid = 1'b0;
            m1_readData      = 32'h0;
         end
         m1_waitRequest = cur_wt ? cyc[0] : 1'b0;
         @(negedge clk);
         chk("m1_rw_exclusive", {31'h0, m1_read & m1_write}, 32'h0);
         if ((m1_read || m1_write) && !m1_waitRequest) begin
            if (exp_mem.size() == 0) fail("unexpected_m1_transfer");
            else begin
               me = exp_mem.pop_front();
               chk("m1_is_write", {31'h0, m1_write}, {31'h0, me.is_wr});
               chk("m1_address", m1_address, me.addr);
               chk("m1_byteEnable", {28'h0, m1_byteEnable}, {28'h0, me.be});
               if (me.is_wr) chk("m1_writeData", m1_writeData, me.data);
            end
            if (m1_read) begin
               r.due  = cyc + cur_lat;
               r.data = (cur_cmd == 4'd1) ? IO_RDATA : (32'hA000_0000 + {28'h0, m1_address[5:2]});
               rq.push_back(r);
            end
            if (m1_write) last_wr_cyc = cyc;
         end
         if (data_wEn) begin
            if (exp_ram.size() == 0 || exp_ram[0].is_tag) fail("unexpected_data_write");
            else begin
               re = exp_ram.pop_front();
               chk("data_wAddr", {23'h0, data_wAddr}, re.addr);
               chk("data_wCh", {30'h0, data_wCh}, {30'h0, re.ch});
               chk("data_wData", data_wData, re.data);
               chk("dre_wEn", {31'h0, dre_wEn}, 32'h1);
               chk("wr_byte_masks", {24'h0, data_wByteEn, dre_wRe}, 32'h0000_00FF);
            end
         end
         if (tag_wEn) begin
            if (exp_ram.size() == 0 || !exp_ram[0].is_tag) fail("unexpected_tag_write");
            else begin
               re = exp_ram.pop_front();
               chk("tag_wAddr", {27'h0, tag_wAddr}, re.addr);
               chk("tag_wCh", {30'h0, tag_wCh}, {30'h0, re.ch});
               chk("tag_wData", tag_wData, re.data);
            end
         end
      end
   end

   task automatic check_zero(input string p);
      chk({p, "_ready"},   {31'h0, m0_cmd_ready}, 32'h0);
      chk({p, "_io_data"}, io_readData, 32'h0);
      chk({p, "_io_vld"},  {31'h0, io_readDataValid}, 32'h0);
      chk({p, "_data_w"},  {data_wData[22:0], data_wAddr} | {28'h0, data_wCh, data_wEn, dre_wEn}, 32'h0);
      chk({p, "_masks"},   {24'h0, data_wByteEn, dre_wRe}, 32'h0);
      chk({p, "_tag_w"},   tag_wData | {24'h0, tag_wAddr, tag_wCh, tag_wEn}, 32'h0);
      chk({p, "_m1_addr"}, m1_address, 32'h0);
      chk({p, "_m1_ctl"},  {26'h0, m1_byteEnable, m1_read, m1_write}, 32'h0);
      chk({p, "_m1_wdat"}, m1_writeData, 32'h0);
   endtask

   task automatic run_vec(input string nm, input vec_t v);
      int n;
      bit got;
      logic [31:0] base;
      cur_wt  = v.wt;
      cur_lat = v.lat;
      cur_cmd = v.cmd;
      base    = v.addr & 32'hFFFF_FFC0;
      if (v.cmd == 4'd2) begin
         for (int i = 0; i < 16; i++) begin
            push_mem(1'b0, base + 32'(4 * i), 4'hF, 32'h0);
            push_ram(1'b0, 32'(v.exp_set * 16 + i), v.exp_way, 32'hA000_0000 + 32'(i));
         end
         push_ram(1'b1, 32'(v.exp_set), v.exp_way, v.exp_tag);
      end else if (v.cmd == 4'd1) begin
         push_mem(v.wr, v.addr, v.be, v.wr ? v.wdata : 32'h0);
      end else if (v.cmd == 4'd3) begin
         for (int s = 0; s < 32; s++)
            for (int w = 0; w < 4; w++)
               push_ram(1'b1, 32'(s), 2'(w), 32'h0);
      end
      @(posedge clk); #1;
      m0_cmd = v.cmd; req_address = v.addr; req_byteEnable = v.be;
      req_read = v.rd; req_write = v.wr; req_writeData = v.wdata;
      isHaveFreeBlock = v.free; freeBlockNum = v.fnum;
      m0_cmd_valid = 1'b1;
      got = 1'b0;
      n = 0;
      while (!got && n < 2000) begin
         @(negedge clk);
         n++;
         if (m0_cmd_ready) got = 1'b1;
      end
      if (!got) fail({nm, "_ready_timeout"});
      else begin
         chk({nm, "_io_valid"}, {31'h0, io_readDataValid}, {31'h0, (v.cmd == 4'd1) && v.rd && !v.wr});
         if (v.cmd == 4'd1 && v.rd) chk({nm, "_io_data"}, io_readData, v.exp_io);
         if (v.cmd == 4'd1 && v.wr) chk({nm, "_wr_ready_lat"}, cyc, last_wr_cyc + 1);
         chk({nm, "_ram_left"}, exp_ram.size(), 32'h0);
         chk({nm, "_m1_left"}, exp_mem.size(), 32'h0);
      end
      @(posedge clk); #1;
      m0_cmd_valid = 1'b0;
      @(negedge clk);
      chk({nm, "_ready_single"}, {31'h0, m0_cmd_ready}, 32'h0);
      exp_mem.delete();
      exp_ram.delete();
   endtask

   vec_t vecs[12];
   vec_t vpost;

   initial begin
      int  n;
      bit  hit;
      //                cmd    addr           be     rd    wr    wdata         fr    fn     wt    lat way    set tag            io
      vecs[0]  = '{4'd2, 32'h0000_1A48, 4'h0, 1'b0, 1'b0, 32'h0,        1'b1, 2'd2, 1'b0, 1, 2'd2, 9,  32'h8000_0003, 32'h0};
      vecs[1]  = '{4'd2, 32'h0000_1A48, 4'h0, 1'b0, 1'b0, 32'h0,        1'b1, 2'd2, 1'b1, 4, 2'd2, 9,  32'h8000_0003, 32'h0};
      vecs[2]  = '{4'd2, 32'h0000_0000, 4'h0, 1'b0, 1'b0, 32'h0,        1'b0, 2'd3, 1'b0, 1, 2'd0, 0,  32'h8000_0000, 32'h0};
      vecs[3]  = '{4'd2, 32'h0000_0840, 4'h0, 1'b0, 1'b0, 32'h0,        1'b0, 2'd3, 1'b0, 1, 2'd1, 1,  32'h8000_0001, 32'h0};
      vecs[4]  = '{4'd2, 32'h0000_1080, 4'h0, 1'b0, 1'b0, 32'h0,        1'b0, 2'd3, 1'b0, 3, 2'd2, 2,  32'h8000_0002, 32'h0};
      vecs[5]  = '{4'd2, 32'h0000_7FC0, 4'h0, 1'b0, 1'b0, 32'h0,        1'b0, 2'd3, 1'b1, 2, 2'd3, 31, 32'h8000_000F, 32'h0};
      vecs[6]  = '{4'd2, 32'hFFFF_F800, 4'h0, 1'b0, 1'b0, 32'h0,        1'b0, 2'd3, 1'b0, 1, 2'd0, 0,  32'h801F_FFFF, 32'h0};
      vecs[7]  = '{4'd1, 32'hF000_0010, 4'hF, 1'b1, 1'b0, 32'h0,        1'b1, 2'd0, 1'b0, 2, 2'd0, 0,  32'h0,         32'h1234_5678};
      vecs[8]  = '{4'd1, 32'hF000_0004, 4'h3, 1'b0, 1'b1, 32'h0000_55AA, 1'b1, 2'd0, 1'b1, 1, 2'd0, 0,  32'h0,         32'h0};
      vecs[9]  = '{4'd3, 32'h0000_0000, 4'h0, 1'b0, 1'b0, 32'h0,        1'b1, 2'd0, 1'b0, 1, 2'd0, 0,  32'h0,         32'h0};
      vecs[10] = '{4'd2, 32'h0000_0A48, 4'h0, 1'b0, 1'b0, 32'h0,        1'b0, 2'd2, 1'b0, 1, 2'd0, 9,  32'h8000_0001, 32'h0};
      vecs[11] = '{4'd7, 32'h0000_0100, 4'h0, 1'b0, 1'b0, 32'h0,        1'b1, 2'd1, 1'b0, 1, 2'd0, 0,  32'h0,         32'h0};
      vpost    = '{4'd2, 32'h0000_0040, 4'h0, 1'b0, 1'b0, 32'h0,        1'b0, 2'd1, 1'b0, 1, 2'd0, 1,  32'h8000_0000, 32'h0};

      rest = 1'b1;
      m0_cmd = 4'd0; m0_cmd_valid = 1'b0; req_address = 32'h0; req_byteEnable = 4'h0;
      req_read = 1'b0; req_write = 1'b0; req_writeData = 32'h0;
      isHaveFreeBlock = 1'b0; freeBlockNum = 2'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      @(posedge clk); #1;
      rest = 1'b0;

      for (int i = 0; i < 12; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // Reset in the middle of a refill, right as word 7 is written.
      cur_wt = 1'b0; cur_lat = 1; cur_cmd = 4'd2;
      for (int i = 0; i < 16; i++) push_mem(1'b0, 32'h0000_2000 + 32'(4 * i), 4'hF, 32'h0);
      for (int i = 0; i < 8; i++)  push_ram(1'b0, 32'(i), 2'd1, 32'hA000_0000 + 32'(i));
      @(posedge clk); #1;
      m0_cmd = 4'd2; req_address = 32'h0000_2000; isHaveFreeBlock = 1'b1; freeBlockNum = 2'd1;
      m0_cmd_valid = 1'b1;
      hit = 1'b0;
      n = 0;
      while (!hit && n < 200) begin
         @(negedge clk);
         n++;
         if (data_wEn && data_wAddr[3:0] == 4'd7) hit = 1'b1;
      end
      if (!hit) fail("rst_word7_timeout");
      rest = 1'b1;
      m0_cmd_valid = 1'b0;
      @(posedge clk); #1;
      exp_mem.delete();
      @(negedge clk);
      check_zero("rst_mid");
      chk("rst_words_before", exp_ram.size(), 32'h0);
      @(posedge clk); #1;
      rest = 1'b0;
      repeat (6) @(negedge clk);
      chk("rst_idle_ready", {31'h0, m0_cmd_ready}, 32'h0);
      run_vec("post_rst", vpost);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      errors++;
      checks++;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cache_ri.md
Name: cache_ri

Overview:
- Command executor directly downstream of the cache read/write stage.
- Consumes that stage's m0_cmd/m0_cmd_valid/m0_cmd_ready handshake and performs three operations:
  - line refill from external memory into the data/tag/readable RAMs;
  - uncached single IO read/write;
  - whole-cache invalidate control operation.
- Owns the cache's external memory master port (m1) and the RAM write ports.

Parameters:
- SIZE, 8192, cache capacity in bytes; 4 ways, 16-word (64-byte) lines.
- Derived localparam DAW = log2(SIZE/16): data/readable RAM address width (9 at default).
- Derived localparam TAW = DAW-4: tag RAM set index width.
- Derived localparam TGW = 30-DAW: tag field width.

Ports:
- clk  in  1  clock
- rest  in  1  reset, synchronous, active-high
- m0_cmd  in  4  command: 4'd1 iorw, 4'd2 rb (refill), 4'd3 ctrl (invalidate all), other values = no-op
- m0_cmd_valid  in  1  command valid; upstream holds it until ready
- m0_cmd_ready  out  1  one-cycle completion pulse
- req_address  in  32  captured request address
- req_byteEnable  in  4  captured byte enables
- req_read  in  1  captured read flag
- req_write  in  1  captured write flag
- req_writeData  in  32  captured write data
- isHaveFreeBlock  in  1  tag RAM: set has an invalid way
- freeBlockNum  in  2  tag RAM: index of that way
- io_readData  out  32  IO read result
- io_readDataValid  out  1  one-cycle IO read result strobe
- data_wAddr  out  DAW  {set, word}; also drives the readable (dre) RAM write address
- data_wCh  out  2  way; also used as dre channel
- data_wData  out  32  refill word
- data_wEn  out  1  data RAM write enable
- data_wByteEn  out  4  always 4'hF
- dre_wRe  out  4  readable bits, always 4'hF
- dre_wEn  out  1  readable RAM write enable, equal to data_wEn
- tag_wAddr  out  TAW  set index
- tag_wCh  out  2  way
- tag_wData  out  32  bit31 valid, [TGW-1:0] tag
- tag_wEn  out  1  tag RAM write enable
- m1_address  out  32  memory master address
- m1_byteEnable  out  4  memory master byte enables
- m1_read  out  1  memory master read request
- m1_write  out  1  memory master write request
- m1_writeData  out  32  memory master write data
- m1_waitRequest  in  1  memory stall
- m1_readData  in  32  memory read data
- m1_readDataValid  in  1  memory read data valid

Behaviour:
- Address split: word = addr[5:2], set = addr[DAW+1:6], tag = addr[31:DAW+2].
- Reset (rest=1 at a clk edge):
  - state goes to IDLE;
  - all outputs go to 0, including victim counter, io_readData and m1_address.
  - Reset mid-operation abandons it with no tag write, so a partial line stays invalid.
- IDLE: when m0_cmd_valid=1, latch cmd and req_* signals, and latch way = isHaveFreeBlock ? freeBlockNum : victim. Then go to:
  - IO_REQ for iorw;
  - RB_REQ for rb;
  - INV for ctrl;
  - DONE for anything else.
- IO_REQ:
  - Drives m1_address=req_address, m1_byteEnable=req_byteEnable and m1_writeData.
  - Drives m1_read=req_read or m1_write=req_write.
  - Transfer is accepted when !m1_waitRequest.
  - A write goes to DONE on accept; a read goes to IO_WAIT.
- IO_WAIT: on m1_readDataValid, register m1_readData into io_readData and go to DONE. io_readDataValid pulses in the DONE cycle.
- RB_REQ:
  - m1_read=1, m1_byteEnable=4'hF, m1_address = {line base, issue count, 2'b00}.
  - Issue count (4-bit) increments on each accepted read; pipelined reads, up to 16 outstanding.
  - After the 16th accept, go to RB_DRAIN.
- Return path (RB_REQ and RB_DRAIN): each m1_readDataValid writes the word on the same cycle:
  - data_wEn=dre_wEn=1;
  - data_wAddr = {set, return count};
  - data_wCh = way;
  - return count (4-bit) increments.
- After return count wraps from 15, go to RB_TAG.
- RB_TAG: one cycle with tag_wEn=1, tag_wAddr=set, tag_wCh=way, tag_wData={1'b1, zeros, tag}.
  - If the way came from the victim counter (no free way), victim increments (2-bit wrap).
  - Then go to DONE.
  - The tag is written last so the line cannot hit before all 16 words are present.
- INV: iterate {set, way} from 0 to 4*2^TAW-1, one tag write per cycle with tag_wData=0. After the last write, go to DONE. The victim counter is cleared.
- DONE: m0_cmd_ready=1 for exactly one cycle, then IDLE. A command re-presented on the following cycle is accepted normally.
- m1_read and m1_write are never asserted together, and never in IDLE, DONE or INV.

Test Plan:
- rb, req_address=0x0000_1A48, isHaveFreeBlock=1, freeBlockNum=2, zero-wait memory returning word i = 0xA000_0000+i:
  - m1 reads 0x1A40..0x1A7C;
  - 16 data writes at addr {set 9, word 0..15}, ch 2;
  - tag write set 9, ch 2, data 0x8000_0003;
  - ready pulse once.
- Same refill with m1_waitRequest toggling every other cycle and readDataValid delayed 3 cycles -> identical RAM write contents and order; ready after the last tag write.
- Four consecutive rb with isHaveFreeBlock=0 -> ways 0,1,2,3, then way 0 again on the fifth.
- iorw read, addr 0xF000_0010, be 4'hF, memory returns 0x1234_5678 after 2 cycles -> io_readData=0x1234_5678, io_readDataValid and m0_cmd_ready both pulse in the same cycle.
- iorw write, 0xF000_0004, be 4'b0011, data 0x55AA -> single m1_write held through waitRequest; ready one cycle after accept; no RAM writes.
- ctrl, SIZE=8192 -> 128 tag writes of 0 covering sets 0..31 × ways 0..3, then ready.
- Reset asserted at refill word 7 -> no tag write, all outputs 0, IDLE next cycle.
